sdram_cmd_timing_scheduler: RTL and testbench

Timing scheduler between the active/precharge insertion stage and the SDRAM command executor. It takes logical SDRAM commands in order and holds each one until every applicable JEDEC spacing constraint has elapsed. The constraints are tRCD, tRP, tRAS, tRRD, tWR, tRFC, tMRD and data-bus burst occupancy. Commands leave in strict arrival order; the block never reorders or drops them.

---
 rtl/sdram_cmd_timing_scheduler.sv | 244 ++++++++++++++++++++++++
 tb/tb_sdram_cmd_timing_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_timing_scheduler.sv
// ---------------------------------------------------------------------------
// sdram_cmd_timing_scheduler
//
// Sits between the active/precharge insertion stage and the SDRAM command
// executor. Each incoming command is held until all JEDEC spacing
// constraints that apply to it have elapsed:
//   tRCD, tRP, tRAS, tRRD, tWR, tRFC, tMRD, and data-bus burst occupancy.
// Commands leave in strict arrival order and are never dropped.
//
// Ports
//   clk, rst_n          : clock; asynchronous active-low reset
//   s_axis_cmd_data     : {BS[15:14], A10..A0[13:3], cmd[2:0]}
//   s_axis_cmd_user     : {auto stop-burst, burst length-1}
//                         (only used when burst_len = -1)
//   s_axis_cmd_valid    : upstream valid
//   s_axis_cmd_ready    : upstream ready
//   m_axis_cmd_data     : command forwarded to the executor
//   m_axis_cmd_user     : user field forwarded to the executor
//   m_axis_cmd_valid    : downstream valid
//   m_axis_cmd_ready    : downstream ready
//   sched_idle          : every spacing timer is zero
//
// Timer convention: a timer loaded with t-1 on the handshake cycle k
// releases its dependent command for a handshake at cycle k+t. A load
// never shortens a pending constraint; it keeps the larger of the new value
// and the already-decremented remaining value.
// ---------------------------------------------------------------------------
module sdram_cmd_timing_scheduler #(
  parameter int    burst_len            = 4,
  parameter string allow_auto_precharge = "true",
  parameter int    t_rcd                = 3,
  parameter int    t_rp                 = 3,
  parameter int    t_ras                = 6,
  parameter int    t_rrd                = 2,
  parameter int    t_wr                 = 2,
  parameter int    t_rfc                = 9,
  parameter int    t_mrd                = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] s_axis_cmd_data,
  input  logic [8:0]  s_axis_cmd_user,
  input  logic        s_axis_cmd_valid,
  output logic        s_axis_cmd_ready,
  output logic [15:0] m_axis_cmd_data,
  output logic [8:0]  m_axis_cmd_user,
  output logic        m_axis_cmd_valid,
  input  logic        m_axis_cmd_ready,
  output logic        sched_idle
);

  localparam logic [2:0] CMD_ACT  = 3'b000;
  localparam logic [2:0] CMD_PRE  = 3'b001;
  localparam logic [2:0] CMD_WR   = 3'b010;
  localparam logic [2:0] CMD_RD   = 3'b011;
  localparam logic [2:0] CMD_STOP = 3'b100;
  localparam logic [2:0] CMD_REF  = 3'b101;
  localparam logic [2:0] CMD_LMR  = 3'b110;

  // Full-page bursts take their length from the user field; A10 then cannot
  // mean auto-precharge because the burst has no natural end.
  localparam bit         FULL_PAGE = (burst_len == -1);
  localparam bit         AP_EN     = !FULL_PAGE && (allow_auto_precharge == "true");
  localparam logic [9:0] FIXED_LEN = FULL_PAGE ? 10'd1 : 10'(burst_len);

  localparam logic [8:0] RCD_LD = 9'(t_rcd - 1);
  localparam logic [8:0] RAS_LD = 9'(t_ras - 1);
  localparam logic [8:0] RRD_LD = 9'(t_rrd - 1);
  localparam logic [8:0] RP_LD  = 9'(t_rp - 1);
  localparam logic [8:0] RFC_LD = 9'(t_rfc - 1);
  localparam logic [8:0] MRD_LD = 9'(t_mrd - 1);

  function automatic logic [8:0] sat_dec(input logic [8:0] v);
    return (v == 9'd0) ? 9'd0 : (v - 9'd1);
  endfunction

  function automatic logic [8:0] max9(input logic [8:0] a, input logic [8:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [8:0] rcd_r [4];
  logic [8:0] ras_r [4];
  logic [8:0] rp_r  [4];
  logic [8:0] wr_r  [4];
  logic [8:0] rrd_r, rfc_r, mrd_r, bus_r;

  logic [8:0] rcd_nxt_s [4];
  logic [8:0] ras_nxt_s [4];
  logic [8:0] rp_nxt_s  [4];
  logic [8:0] wr_nxt_s  [4];
  logic [8:0] rrd_nxt_s, rfc_nxt_s, mrd_nxt_s, bus_nxt_s;

  logic [1:0] bank_s;
  logic       a10_s;
  logic [2:0] code_s;
  logic [3:0] bank_hit_s;
  logic       is_act_s, is_pre_s, is_wr_s, is_rd_s, is_stop_s, is_ref_s, is_lmr_s;
  logic       all_rp_zero_s, all_wr_zero_s, all_ras_zero_s, any_busy_s;
  logic       bus_zero_s, g_s, elig_s, hs_s, ap_s;
  logic [9:0] blen_s;
  logic [8:0] bus_ld_s, wr_ld_s, rp_rd_ap_s, rp_wr_ap_s;

  assign bank_s     = s_axis_cmd_data[15:14];
  assign a10_s      = s_axis_cmd_data[13];
  assign code_s     = s_axis_cmd_data[2:0];
  assign bank_hit_s = 4'b0001 << bank_s;
  assign ap_s       = AP_EN && a10_s;

  // Burst length in use and the burst-dependent timer load values (10-bit
  // intermediates so a 256-beat burst plus tWR cannot wrap before truncation).
  assign blen_s     = FULL_PAGE ? ({2'b00, s_axis_cmd_user[7:0]} + 10'd1) : FIXED_LEN;
  assign bus_ld_s   = 9'(blen_s - 10'd1);
  assign wr_ld_s    = 9'(blen_s + 10'(t_wr) - 10'd1);
  assign rp_rd_ap_s = 9'(blen_s + 10'(t_rp) - 10'd1);
  assign rp_wr_ap_s = 9'(blen_s + 10'(t_wr) + 10'(t_rp) - 10'd1);

  assign bus_zero_s = (bus_r == 9'd0);
  assign g_s        = (rfc_r == 9'd0) && (mrd_r == 9'd0);

  // Zero-latency pass-through; valid/ready never depend on each other.
  assign m_axis_cmd_data  = s_axis_cmd_data;
  assign m_axis_cmd_user  = s_axis_cmd_user;
  assign m_axis_cmd_valid = s_axis_cmd_valid && elig_s;
  assign s_axis_cmd_ready = m_axis_cmd_ready && elig_s;
  assign hs_s             = s_axis_cmd_valid && m_axis_cmd_ready && elig_s;
  assign sched_idle       = !any_busy_s;

  // Per-bank summary flags used by all-bank commands and by sched_idle.
  always_comb begin
    all_rp_zero_s  = 1'b1;
    all_wr_zero_s  = 1'b1;
    all_ras_zero_s = 1'b1;
    any_busy_s     = (rrd_r != 9'd0) || (rfc_r != 9'd0) || (mrd_r != 9'd0) || (bus_r != 9'd0);
    for (int b = 0; b < 4; b++) begin
      all_rp_zero_s  = all_rp_zero_s  && (rp_r[b]  == 9'd0);
      all_wr_zero_s  = all_wr_zero_s  && (wr_r[b]  == 9'd0);
      all_ras_zero_s = all_ras_zero_s && (ras_r[b] == 9'd0);
      any_busy_s     = any_busy_s || (rcd_r[b] != 9'd0) || (ras_r[b] != 9'd0)
                       || (rp_r[b] != 9'd0) || (wr_r[b] != 9'd0);
    end
  end

  // Command decode and eligibility of the command at the head of the stream.
  always_comb begin
    is_act_s  = 1'b0;
    is_pre_s  = 1'b0;
    is_wr_s   = 1'b0;
    is_rd_s   = 1'b0;
    is_stop_s = 1'b0;
    is_ref_s  = 1'b0;
    is_lmr_s  = 1'b0;
    elig_s    = 1'b1;
    case (code_s)
      CMD_ACT: begin
        is_act_s = 1'b1;
        elig_s   = (rp_r[bank_s] == 9'd0) && (rrd_r == 9'd0) && g_s;
      end
      CMD_PRE: begin
        is_pre_s = 1'b1;
        elig_s   = a10_s ? (all_ras_zero_s && all_wr_zero_s && bus_zero_s && g_s)
                         : ((ras_r[bank_s] == 9'd0) && (wr_r[bank_s] == 9'd0) && bus_zero_s && g_s);
      end
      CMD_WR: begin
        is_wr_s = 1'b1;
        elig_s  = (rcd_r[bank_s] == 9'd0) && bus_zero_s && g_s;
      end
      CMD_RD: begin
        is_rd_s = 1'b1;
        elig_s  = (rcd_r[bank_s] == 9'd0) && bus_zero_s && g_s;
      end
      CMD_STOP: begin
        is_stop_s = 1'b1;
        elig_s    = 1'b1;
      end
      CMD_REF: begin
        is_ref_s = 1'b1;
        elig_s   = all_rp_zero_s && all_wr_zero_s && bus_zero_s && g_s;
      end
      CMD_LMR: begin
        is_lmr_s = 1'b1;
        elig_s   = all_rp_zero_s && all_wr_zero_s && bus_zero_s && g_s;
      end
      default: begin
        elig_s = 1'b1;
      end
    endcase
  end

  // Next timer values: saturating decrement, or max(remaining, load) on hs.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      rcd_nxt_s[b] = (hs_s && is_act_s && bank_hit_s[b])
                     ? max9(sat_dec(rcd_r[b]), RCD_LD) : sat_dec(rcd_r[b]);
      ras_nxt_s[b] = (hs_s && is_act_s && bank_hit_s[b])
                     ? max9(sat_dec(ras_r[b]), RAS_LD) : sat_dec(ras_r[b]);
      wr_nxt_s[b]  = (hs_s && is_wr_s && bank_hit_s[b])
                     ? max9(sat_dec(wr_r[b]), wr_ld_s) : sat_dec(wr_r[b]);
      // Explicit precharge (single or all) or an auto-precharging burst.
      rp_nxt_s[b]  = (hs_s && is_pre_s && (bank_hit_s[b] || a10_s))
                     ? max9(sat_dec(rp_r[b]), RP_LD)
                     : (hs_s && is_rd_s && ap_s && bank_hit_s[b])
                     ? max9(sat_dec(rp_r[b]), rp_rd_ap_s)
                     : (hs_s && is_wr_s && ap_s && bank_hit_s[b])
                     ? max9(sat_dec(rp_r[b]), rp_wr_ap_s)
                     : sat_dec(rp_r[b]);
    end
    rrd_nxt_s = (hs_s && is_act_s) ? max9(sat_dec(rrd_r), RRD_LD) : sat_dec(rrd_r);
    rfc_nxt_s = (hs_s && is_ref_s) ? max9(sat_dec(rfc_r), RFC_LD) : sat_dec(rfc_r);
    mrd_nxt_s = (hs_s && is_lmr_s) ? max9(sat_dec(mrd_r), MRD_LD) : sat_dec(mrd_r);
    // STOP BURST frees the data bus at once; the write-recovery timer is
    // deliberately left running.
    bus_nxt_s = (hs_s && is_stop_s) ? 9'd0
              : (hs_s && (is_rd_s || is_wr_s)) ? max9(sat_dec(bus_r), bus_ld_s)
              : sat_dec(bus_r);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        rcd_r[b] <= 9'd0;
        ras_r[b] <= 9'd0;
        rp_r[b]  <= 9'd0;
        wr_r[b]  <= 9'd0;
      end
      rrd_r <= 9'd0;
      rfc_r <= 9'd0;
      mrd_r <= 9'd0;
      bus_r <= 9'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        rcd_r[b] <= rcd_nxt_s[b];
        ras_r[b] <= ras_nxt_s[b];
        rp_r[b]  <= rp_nxt_s[b];
        wr_r[b]  <= wr_nxt_s[b];
      end
      rrd_r <= rrd_nxt_s;
      rfc_r <= rfc_nxt_s;
      mrd_r <= mrd_nxt_s;
      bus_r <= bus_nxt_s;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_timing_scheduler.sv
// ---------------------------------------------------------------------------
// Directed bench for sdram_cmd_timing_scheduler. Two instances share the
// stimulus: dut_a uses default parameters, dut_b runs full-page bursts with
// t_wr = 15. A scoreboard queue holds the expected command and the cycle on
// which its handshake must occur; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_sdram_cmd_timing_scheduler;

  localparam logic [2:0] ACT  = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] WR   = 3'd2;
  localparam logic [2:0] RD   = 3'd3;
  localparam logic [2:0] STOP = 3'd4;
  localparam logic [2:0] REF  = 3'd5;
  localparam logic [2:0] LMR  = 3'd6;

  typedef struct packed {
    logic [15:0] d;
    logic [8:0]  u;
    logic [31:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] s_data;
  logic [8:0]  s_user;
  logic        s_valid;
  logic        m_ready;
  logic        sel;

  logic        s_ready_a, m_valid_a, idle_a;
  logic [15:0] m_data_a;
  logic [8:0]  m_user_a;
  logic        s_ready_b, m_valid_b, idle_b;
  logic [15:0] m_data_b;
  logic [8:0]  m_user_b;

  logic        s_ready, m_valid, idle;
  logic [15:0] m_data;
  logic [8:0]  m_user;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_hs = 0;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sdram_cmd_timing_scheduler dut_a (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_cmd_data  (s_data),
    .s_axis_cmd_user  (s_user),
    .s_axis_cmd_valid (s_valid),
    .s_axis_cmd_ready (s_ready_a),
    .m_axis_cmd_data  (m_data_a),
    .m_axis_cmd_user  (m_user_a),
    .m_axis_cmd_valid (m_valid_a),
    .m_axis_cmd_ready (m_ready),
    .sched_idle       (idle_a)
  );

  sdram_cmd_timing_scheduler #(.burst_len(-1), .t_wr(15)) dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_cmd_data  (s_data),
    .s_axis_cmd_user  (s_user),
    .s_axis_cmd_valid (s_valid),
    .s_axis_cmd_ready (s_ready_b),
    .m_axis_cmd_data  (m_data_b),
    .m_axis_cmd_user  (m_user_b),
    .m_axis_cmd_valid (m_valid_b),
    .m_axis_cmd_ready (m_ready),
    .sched_idle       (idle_b)
  );

  assign s_ready = sel ? s_ready_b : s_ready_a;
  assign m_valid = sel ? m_valid_b : m_valid_a;
  assign idle    = sel ? idle_b    : idle_a;
  assign m_data  = sel ? m_data_b  : m_data_a;
  assign m_user  = sel ? m_user_b  : m_user_a;

  function automatic logic [15:0] mk(input logic [1:0] b, input logic a10, input logic [2:0] c);
    return {b, a10, 10'd0, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Present one command, expect its handshake on cycle exp_c; m_valid must
  // stay low on every earlier cycle. With idle_chk, sched_idle is expected
  // low while held and high on the handshake cycle.
  task automatic issue(input logic [15:0] d, input logic [8:0] u, input int exp_c, input bit idle_chk);
    int n;
    sb.push_back('{d, u, 32'(exp_c)});
    s_data  = d;
    s_user  = u;
    s_valid = 1'b1;
    for (n = 0; n < 400; n++) begin
      @(negedge clk);
      chk("m_valid", 32'(m_valid), 32'(cyc >= exp_c));
      if (idle_chk) chk("sched_idle", 32'(idle), 32'(cyc >= exp_c));
      if (m_valid && m_ready) break;
    end
    chk("hs_timeout", 32'(n < 400), 32'd1);
    last_hs = cyc;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 50; n++) begin
      @(negedge clk);
      if (idle) break;
    end
    chk("idle_timeout", 32'(n < 50), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      chk("hs_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hs_data",  32'(m_data),  32'(e.d));
        chk("hs_user",  32'(m_user),  32'(e.u));
        chk("hs_cycle", 32'(cyc),     e.c);
        chk("hs_ready", 32'(s_ready), 32'd1);
      end
    end
  end

  initial begin
    int a, rd, k, m, s, p, pa, q, kk, x, j, r, z, w, y, k2;
    rst_n   = 1'b0;
    s_data  = 16'd0;
    s_user  = 9'd0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    sel     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_valid_lo", 32'(m_valid), 32'd0);
    s_data  = mk(2'd0, 1'b0, RD);
    s_valid = 1'b1;
    #1;
    chk("rst_valid_follows", 32'(m_valid), 32'd1);
    chk("rst_ready_lo", 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    #1;
    chk("rst_ready_follows", 32'(s_ready), 32'd1);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // tRCD: first command eligible in the release cycle.
    issue(mk(2'd1, 1'b0, ACT), 9'd0, cyc, 1'b0);
    a = last_hs;
    issue(mk(2'd1, 1'b0, RD), 9'd0, a + 3, 1'b0);
    rd = last_hs;

    // Burst spacing and STOP BURST.
    issue(mk(2'd1, 1'b0, WR), 9'd0, rd + 4, 1'b0);
    k = last_hs;
    issue(mk(2'd1, 1'b0, RD), 9'd0, k + 4, 1'b0);
    m = last_hs;
    @(posedge clk);
    #1;
    issue(mk(2'd1, 1'b0, STOP), 9'd0, m + 2, 1'b0);
    issue(mk(2'd1, 1'b0, RD), 9'd0, m + 3, 1'b0);

    // tWR / tRAS, then precharge-all held by bank 2 tRAS.
    wait_idle();
    issue(mk(2'd0, 1'b0, ACT), 9'd0, cyc, 1'b0);
    s = last_hs;
    issue(mk(2'd0, 1'b0, WR), 9'd0, s + 3, 1'b0);
    issue(mk(2'd0, 1'b0, PRE), 9'd0, s + 9, 1'b0);
    issue(mk(2'd2, 1'b0, ACT), 9'd0, s + 10, 1'b0);
    p = last_hs;
    issue(mk(2'd0, 1'b1, PRE), 9'd0, p + 6, 1'b0);
    pa = last_hs;

    // Auto-precharge on read: bank 3 blocked until k+7, bank 2 free at k+1.
    issue(mk(2'd3, 1'b0, ACT), 9'd0, pa + 3, 1'b0);
    q = last_hs;
    issue(mk(2'd3, 1'b1, RD), 9'd0, q + 3, 1'b0);
    kk = last_hs;
    issue(mk(2'd2, 1'b0, ACT), 9'd0, kk + 1, 1'b0);
    issue(mk(2'd3, 1'b0, ACT), 9'd0, kk + 7, 1'b0);
    x = last_hs;

    // Refresh behind rp[1], then ACTIVE after tRFC with sched_idle tracking.
    issue(mk(2'd1, 1'b0, PRE), 9'd0, x + 1, 1'b0);
    j = last_hs;
    issue(mk(2'd0, 1'b0, REF), 9'd0, j + 3, 1'b0);
    r = last_hs;
    issue(mk(2'd0, 1'b0, ACT), 9'd0, r + 9, 1'b1);
    z = last_hs;

    // Load mode then tMRD.
    issue(mk(2'd0, 1'b0, LMR), 9'd0, z + 1, 1'b0);
    issue(mk(2'd1, 1'b0, ACT), 9'd0, z + 3, 1'b0);
    w = last_hs;

    // Downstream stall: eligible at w+3, accepted at w+5; bus load at w+5.
    sb.push_back('{mk(2'd1, 1'b0, RD), 9'd0, 32'(w + 5)});
    s_data  = mk(2'd1, 1'b0, RD);
    s_user  = 9'd0;
    s_valid = 1'b1;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(m_valid), 32'(cyc >= w + 3));
      chk("stall_ready", 32'(s_ready), 32'd0);
      chk("stall_data", 32'(m_data), 32'(mk(2'd1, 1'b0, RD)));
      @(posedge clk);
      #1;
    end
    m_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    issue(mk(2'd1, 1'b0, RD), 9'd0, w + 9, 1'b0);

    // Reset while a READ is held on tRCD.
    issue(mk(2'd2, 1'b0, ACT), 9'd0, w + 10, 1'b0);
    y = last_hs;
    sb.push_back('{mk(2'd2, 1'b0, RD), 9'd0, 32'(y + 2)});
    s_data  = mk(2'd2, 1'b0, RD);
    s_valid = 1'b1;
    @(negedge clk);
    chk("held_on_rcd", 32'(m_valid), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_clears_valid", 32'(m_valid), 32'd1);
    chk("rst_clears_idle", 32'(idle), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    s_valid = 1'b0;

    // Full-page instance.
    chk("sb_empty_a", 32'(sb.size()), 32'd0);
    rst_n = 1'b0;
    sel   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(mk(2'd0, 1'b0, ACT), 9'd0, cyc, 1'b0);
    a = last_hs;
    issue(mk(2'd0, 1'b0, WR), 9'h00F, a + 3, 1'b0);
    k = last_hs;
    issue(mk(2'd0, 1'b0, RD), 9'h10F, k + 16, 1'b0);
    m = last_hs;
    issue(mk(2'd0, 1'b0, WR), 9'h0FF, m + 16, 1'b0);
    k2 = last_hs;
    issue(mk(2'd0, 1'b0, PRE), 9'd0, k2 + 271, 1'b0);

    @(negedge clk);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
